// File: rtl/bldc_motion_sequencer.sv
// rtl/bldc_motion_sequencer.sv - BLDC enable/direction/duty sequencer with duty ramping and fault latching
package bldc_motion_sequencer_pkg;
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } rotation_direction_t;

  typedef logic [2:0] hall_states_t;
endpackage

module bldc_motion_sequencer
  import bldc_motion_sequencer_pkg::*;
#(
  parameter int duty_width          = 11,
  parameter int max_duty            = 1002,
  parameter int stop_timeout_cycles = 5_400_000,
  parameter int prescaler_width     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable_req,
  input  rotation_direction_t        target_dir,
  input  logic [duty_width-1:0]      target_duty,
  input  logic [duty_width-1:0]      ramp_step,
  input  logic [prescaler_width-1:0] ramp_div,
  input  hall_states_t               hall_values,
  input  logic                       hall_error,
  input  logic                       fault_n,
  input  logic                       overcurrent_n,
  input  logic                       fault_clear,
  output logic                       gate_enable,
  output rotation_direction_t        dir,
  output logic [duty_width-1:0]      duty,
  output logic [2:0]                 seq_state,
  output logic [2:0]                 fault_cause,
  output logic                       at_target
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP      = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_WAIT_STOP = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_t;

  localparam int stop_cnt_width = $clog2(stop_timeout_cycles);
  localparam logic [stop_cnt_width-1:0] stop_last = stop_cnt_width'(stop_timeout_cycles - 1);
  localparam logic [duty_width-1:0] max_duty_c = duty_width'(max_duty);
  localparam logic [duty_width-1:0] duty_zero  = '0;

  seq_state_t                 state_q, state_d;
  logic                       fault_s1, fault_s2, oc_s1, oc_s2;
  hall_states_t               hall_s1, hall_s2, hall_prev;
  logic                       hall_change;
  logic [2:0]                 fault_src;
  logic                       fault_entry;
  logic [prescaler_width-1:0] presc;
  logic                       tick;
  logic [stop_cnt_width-1:0]  stop_cnt;
  logic [duty_width-1:0]      eff_target, step_eff, duty_step, duty_d;
  logic                       gate_d, at_target_d;
  rotation_direction_t        dir_d;
  logic [2:0]                 cause_d;

  // Move cur toward goal by at most stp, landing exactly on goal when within reach
  function automatic logic [duty_width-1:0] approach(input logic [duty_width-1:0] cur,
                                                      input logic [duty_width-1:0] goal,
                                                      input logic [duty_width-1:0] stp);
    if (goal >= cur) return (goal - cur <= stp) ? goal : cur + stp;
    else             return (cur - goal <= stp) ? goal : cur - stp;
  endfunction

  assign eff_target  = (target_duty > max_duty_c) ? max_duty_c : target_duty;
  assign step_eff    = (ramp_step == duty_zero) ? duty_width'(1) : ramp_step;
  assign hall_change = (hall_s2 != hall_prev);
  // hall_error only matters while the bridge is actually driven
  assign fault_src   = {hall_error & gate_enable, ~oc_s2, ~fault_s2};
  assign fault_entry = |fault_src;
  // >= rather than == so a shrinking ramp_div cannot strand the prescaler above it
  assign tick        = (presc >= ramp_div);
  assign seq_state   = state_q;

  // Two-flop synchronizers for the asynchronous fault lines and hall inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_s1  <= 1'b1;
      fault_s2  <= 1'b1;
      oc_s1     <= 1'b1;
      oc_s2     <= 1'b1;
      hall_s1   <= '1;
      hall_s2   <= '1;
      hall_prev <= '1;
    end else begin
      fault_s1  <= fault_n;
      fault_s2  <= fault_s1;
      oc_s1     <= overcurrent_n;
      oc_s2     <= oc_s1;
      hall_s1   <= hall_values;
      hall_s2   <= hall_s1;
      hall_prev <= hall_s2;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decision; fault entry overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (enable_req && target_dir != DIR_NONE && fault_cause == 3'b000) state_d = ST_RAMP;
      ST_RAMP:
        if (!enable_req || target_dir != dir) state_d = ST_RAMP_DOWN;
        else if (duty == eff_target)          state_d = ST_RUN;
      ST_RUN:
        if (!enable_req || target_dir != dir) state_d = ST_RAMP_DOWN;
        else if (duty != eff_target)          state_d = ST_RAMP;
      ST_RAMP_DOWN:
        if (duty == duty_zero)                       state_d = ST_WAIT_STOP;
        else if (enable_req && target_dir == dir)    state_d = ST_RAMP;
      ST_WAIT_STOP:
        if (!hall_change && stop_cnt == stop_last) state_d = ST_IDLE;
      ST_FAULT:
        if (fault_clear && !fault_entry) state_d = ST_WAIT_STOP;
      default:
        state_d = ST_IDLE;
    endcase
    if (fault_entry) state_d = ST_FAULT;
  end

  // Next output values derived from the state being entered
  always_comb begin
    duty_step = duty;
    if (tick && state_q == ST_RAMP)           duty_step = approach(duty, eff_target, step_eff);
    else if (tick && state_q == ST_RAMP_DOWN) duty_step = approach(duty, duty_zero, step_eff);
    gate_d      = 1'b0;
    dir_d       = dir;
    duty_d      = duty_zero;
    cause_d     = fault_cause;
    at_target_d = 1'b0;
    case (state_d)
      ST_IDLE: dir_d = DIR_NONE;
      ST_RAMP: begin
        gate_d = 1'b1;
        duty_d = duty_step;
        if (state_q == ST_IDLE) dir_d = target_dir;
      end
      ST_RUN: begin
        gate_d      = 1'b1;
        duty_d      = duty_step;
        at_target_d = 1'b1;
      end
      ST_RAMP_DOWN: begin
        gate_d = 1'b1;
        duty_d = duty_step;
      end
      ST_WAIT_STOP: if (state_q == ST_FAULT) cause_d = 3'b000;
      ST_FAULT:     cause_d = fault_cause | fault_src;
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_enable <= 1'b0;
      dir         <= DIR_NONE;
      duty        <= '0;
      fault_cause <= 3'b000;
      at_target   <= 1'b0;
    end else begin
      gate_enable <= gate_d;
      dir         <= dir_d;
      duty        <= duty_d;
      fault_cause <= cause_d;
      at_target   <= at_target_d;
    end
  end

  // Ramp prescaler: restarts on entry to either ramp state, idle at 0 elsewhere
  always_ff @(posedge clk) begin
    if (reset)                                                  presc <= '0;
    else if (state_d == ST_RAMP && state_q != ST_RAMP)          presc <= '0;
    else if (state_d == ST_RAMP_DOWN && state_q != ST_RAMP_DOWN) presc <= '0;
    else if (state_q == ST_RAMP || state_q == ST_RAMP_DOWN)     presc <= tick ? '0 : presc + prescaler_width'(1);
    else                                                        presc <= '0;
  end

  // Rotor-stop timer: counts quiet cycles in WAIT_STOP, restarts on any hall edge
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_WAIT_STOP) stop_cnt <= '0;
    else if (hall_change)                 stop_cnt <= '0;
    else if (stop_cnt != stop_last)       stop_cnt <= stop_cnt + stop_cnt_width'(1);
  end

endmodule

// File: tb/tb_bldc_motion_sequencer.sv
// tb/tb_bldc_motion_sequencer.sv - directed self-checking bench for bldc_motion_sequencer
module tb_bldc_motion_sequencer;
  import bldc_motion_sequencer_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable_req;
  rotation_direction_t target_dir;
  logic [10:0]         target_duty;
  logic [10:0]         ramp_step;
  logic [15:0]         ramp_div;
  hall_states_t        hall_values;
  logic                hall_error;
  logic                fault_n;
  logic                overcurrent_n;
  logic                fault_clear;
  logic                gate_enable;
  rotation_direction_t dir;
  logic [10:0]         duty;
  logic [2:0]          seq_state;
  logic [2:0]          fault_cause;
  logic                at_target;

  int   checks   = 0;
  int   failures = 0;
  logic gate_dropped;

  bldc_motion_sequencer #(
    .duty_width(11),
    .max_duty(1002),
    .stop_timeout_cycles(64),
    .prescaler_width(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_req(enable_req),
    .target_dir(target_dir),
    .target_duty(target_duty),
    .ramp_step(ramp_step),
    .ramp_div(ramp_div),
    .hall_values(hall_values),
    .hall_error(hall_error),
    .fault_n(fault_n),
    .overcurrent_n(overcurrent_n),
    .fault_clear(fault_clear),
    .gate_enable(gate_enable),
    .dir(dir),
    .duty(duty),
    .seq_state(seq_state),
    .fault_cause(fault_cause),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic watch_n(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (gate_enable !== 1'b1) gate_dropped = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int limit);
    int n = 0;
    while (seq_state !== st && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(seq_state), 32'(st));
  endtask

  initial begin
    reset = 1'b1; enable_req = 1'b0; target_dir = DIR_NONE; target_duty = '0;
    ramp_step = '0; ramp_div = '0; hall_values = 3'b000; hall_error = 1'b0;
    fault_n = 1'b1; overcurrent_n = 1'b1; fault_clear = 1'b0; gate_dropped = 1'b0;
    step_n(2);
    check("rst_state", 32'(seq_state), 0);
    check("rst_gate", 32'(gate_enable), 0);
    check("rst_dir", 32'(dir), 32'(DIR_NONE));
    check("rst_duty", 32'(duty), 0);
    check("rst_cause", 32'(fault_cause), 0);
    check("rst_at_target", 32'(at_target), 0);
    reset = 1'b0;

    // Ramp up CW to 350 in steps of 100, tick every 4 cycles
    ramp_div = 16'd3; ramp_step = 11'd100; target_duty = 11'd350; target_dir = DIR_CW;
    step();
    check("idle_without_enable", 32'(seq_state), 0);
    enable_req = 1'b1;
    step();
    check("up_state_ramp", 32'(seq_state), 1);
    check("up_dir", 32'(dir), 32'(DIR_CW));
    check("up_gate", 32'(gate_enable), 1);
    check("up_duty0", 32'(duty), 0);
    step_n(3);
    check("up_duty_pre_tick", 32'(duty), 0);
    step();
    check("up_duty100", 32'(duty), 100);
    step_n(4);
    check("up_duty200", 32'(duty), 200);
    step_n(4);
    check("up_duty300", 32'(duty), 300);
    step_n(4);
    check("up_duty350", 32'(duty), 350);
    check("up_still_ramp", 32'(seq_state), 1);
    step();
    check("up_run", 32'(seq_state), 2);
    check("up_at_target", 32'(at_target), 1);

    // Reversal CW -> CCW with hall activity for 20 cycles
    target_dir = DIR_CCW;
    for (int i = 0; i < 20; i++) begin
      hall_values = hall_values ^ 3'b001;
      step();
      if (i == 0) begin
        check("rev_ramp_down", 32'(seq_state), 3);
        check("rev_at_target_low", 32'(at_target), 0);
      end
      if (i == 4) check("rev_duty250", 32'(duty), 250);
      if (i == 16) begin
        check("rev_duty_zero", 32'(duty), 0);
        check("rev_gate_still_on", 32'(gate_enable), 1);
      end
      if (i == 17) begin
        check("rev_gate_off", 32'(gate_enable), 0);
        check("rev_wait_stop", 32'(seq_state), 4);
        check("rev_dir_held", 32'(dir), 32'(DIR_CW));
      end
    end
    step_n(65);
    check("rev_still_waiting", 32'(seq_state), 4);
    step();
    check("rev_idle", 32'(seq_state), 0);
    check("rev_dir_none", 32'(dir), 32'(DIR_NONE));
    step();
    check("rev_restart_state", 32'(seq_state), 1);
    check("rev_dir_ccw", 32'(dir), 32'(DIR_CCW));
    check("rev_restart_gate", 32'(gate_enable), 1);
    wait_state("rev_run", 3'd2, 100);
    check("rev_run_duty", 32'(duty), 350);

    // Clamp to 1002 with zero step and tick every cycle
    target_duty = 11'd2000; ramp_step = 11'd0; ramp_div = 16'd0;
    step();
    check("clamp_ramp", 32'(seq_state), 1);
    step();
    check("clamp_duty351", 32'(duty), 351);
    step_n(99);
    check("clamp_duty450", 32'(duty), 450);
    step_n(552);
    check("clamp_duty1002", 32'(duty), 1002);
    check("clamp_still_ramp", 32'(seq_state), 1);
    step();
    check("clamp_run", 32'(seq_state), 2);
    step_n(7);
    check("clamp_hold1002", 32'(duty), 1002);

    // Abort a ramp-down at 500 and climb back
    target_duty = 11'd500; ramp_step = 11'd100; ramp_div = 16'd3;
    step();
    wait_state("abort_setup_run", 3'd2, 60);
    check("abort_setup_duty", 32'(duty), 500);
    enable_req = 1'b0;
    gate_dropped = 1'b0;
    watch_n(1);
    check("abort_ramp_down", 32'(seq_state), 3);
    watch_n(4);
    check("abort_duty400", 32'(duty), 400);
    watch_n(4);
    check("abort_duty300", 32'(duty), 300);
    enable_req = 1'b1;
    watch_n(1);
    check("abort_back_ramp", 32'(seq_state), 1);
    watch_n(4);
    check("abort_up400", 32'(duty), 400);
    watch_n(4);
    check("abort_up500", 32'(duty), 500);
    watch_n(1);
    check("abort_run", 32'(seq_state), 2);
    check("abort_gate_never_dropped", 32'(gate_dropped), 0);

    // Reset in RUN at 700
    target_duty = 11'd700;
    step();
    wait_state("rst_mid_run", 3'd2, 40);
    check("rst_mid_duty700", 32'(duty), 700);
    reset = 1'b1;
    step();
    check("rst_mid_gate", 32'(gate_enable), 0);
    check("rst_mid_duty", 32'(duty), 0);
    check("rst_mid_dir", 32'(dir), 32'(DIR_NONE));
    check("rst_mid_state", 32'(seq_state), 0);
    check("rst_mid_cause", 32'(fault_cause), 0);
    reset = 1'b0;
    enable_req = 1'b0;
    step();

    // Overcurrent pulse mid-ramp, blocked clear, then a real clear
    target_dir = DIR_CW; target_duty = 11'd350; enable_req = 1'b1;
    step();
    check("oc_ramp", 32'(seq_state), 1);
    step_n(4);
    check("oc_duty100", 32'(duty), 100);
    overcurrent_n = 1'b0;
    step();
    overcurrent_n = 1'b1;
    step();
    check("oc_not_yet", 32'(seq_state), 1);
    step();
    check("oc_fault_state", 32'(seq_state), 5);
    check("oc_gate_off", 32'(gate_enable), 0);
    check("oc_duty_zero", 32'(duty), 0);
    check("oc_cause", 32'(fault_cause), 32'(3'b010));
    check("oc_dir_held", 32'(dir), 32'(DIR_CW));
    fault_n = 1'b0;
    step_n(3);
    check("oc_cause_or", 32'(fault_cause), 32'(3'b011));
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    check("oc_clear_ignored", 32'(seq_state), 5);
    check("oc_clear_ignored_cause", 32'(fault_cause), 32'(3'b011));
    enable_req = 1'b0;
    fault_n = 1'b1;
    step_n(3);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    check("oc_to_wait_stop", 32'(seq_state), 4);
    check("oc_cause_cleared", 32'(fault_cause), 0);
    step_n(63);
    check("oc_still_waiting", 32'(seq_state), 4);
    step();
    check("oc_idle", 32'(seq_state), 0);
    check("oc_idle_dir", 32'(dir), 32'(DIR_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bldc_motion_sequencer.md
Name: bldc_motion_sequencer

Overview:
- Sits between the register file and the BLDC PWM/commutation datapath.
- Converts software enable, direction and duty requests into safe gate_enable, dir and duty values.
- Ramps duty at a programmable rate. A direction reversal always ramps to zero and waits for the rotor to stop before switching.
- Latches driver, overcurrent and hall faults and forces a shutdown until software clears them.

Parameters:
- duty_width, 11: width of duty, target_duty and ramp_step.
- max_duty, 1002: duty ceiling. target_duty above it is clamped to it.
- stop_timeout_cycles, 5_400_000: clk cycles with no hall change before the rotor is considered stopped (100 ms at 54 MHz).
- prescaler_width, 16: width of ramp_div and the internal ramp prescaler.

Ports:
- clk  in  1  single clock. All logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_req  in  1  software run request (level).
- target_dir  in  rotation_direction_t  requested direction: DIR_NONE, DIR_CW or DIR_CCW.
- target_duty  in  duty_width  requested duty, in PWM ticks.
- ramp_step  in  duty_width  duty change per ramp tick. 0 is treated as 1.
- ramp_div  in  prescaler_width  clk cycles between ramp ticks minus 1.
- hall_values  in  hall_states_t  raw hall sensor inputs.
- hall_error  in  1  commutation table error.
- fault_n  in  1  driver fault, active low, asynchronous.
- overcurrent_n  in  1  overcurrent warning, active low, asynchronous.
- fault_clear  in  1  single-cycle pulse that clears a latched fault.
- gate_enable  out  1  registered driver gate enable.
- dir  out  rotation_direction_t  direction applied to the commutator.
- duty  out  duty_width  duty applied to the PWM generator.
- seq_state  out  3  current state encoding.
- fault_cause  out  3  latched {hall_error, overcurrent, driver fault}.
- at_target  out  1  high in RUN only.

Behaviour:
- Reset (synchronous, active-high) values:
  - state IDLE, gate_enable 0, dir DIR_NONE, duty 0, fault_cause 0, at_target 0.
  - prescaler and stop counter 0.
  - Synchronizer flops set to the inactive level (1).
- Input synchronization:
  - fault_n and overcurrent_n pass through 2-flop synchronizers.
  - hall_values passes through a 2-flop synchronizer plus a previous-value register. hall_change is high when the synced value differs from the previous value.
- Outputs are registered. A state transition is visible on seq_state and the outputs one cycle after the deciding edge.
- State encoding: IDLE=0, RAMP=1, RUN=2, RAMP_DOWN=3, WAIT_STOP=4, FAULT=5.
- Ramp tick:
  - Prescaler counts 0..ramp_div, then wraps. The tick fires in the cycle the prescaler equals ramp_div.
  - The prescaler clears on entry to RAMP and to RAMP_DOWN.
  - ramp_div=0 gives a tick every cycle.
- Duty arithmetic:
  - eff_target = min(target_duty, max_duty); step = max(ramp_step, 1).
  - On a tick, if |eff_target-duty| <= step then duty <= eff_target, else duty moves by step toward eff_target.
  - Duty never overshoots and never wraps.
- IDLE:
  - Outputs: gate_enable 0, duty 0, dir DIR_NONE.
  - If enable_req=1 and target_dir!=DIR_NONE and fault_cause==0: dir <= target_dir, go to RAMP.
- RAMP:
  - gate_enable 1; duty ramps toward eff_target.
  - When duty==eff_target, go to RUN.
  - If enable_req=0, or target_dir!=dir, go to RAMP_DOWN.
- RUN:
  - gate_enable 1, at_target 1.
  - If eff_target!=duty, go to RAMP.
  - If enable_req=0, or target_dir!=dir, go to RAMP_DOWN.
- RAMP_DOWN:
  - Duty ramps toward 0. On duty==0: gate_enable <= 0, go to WAIT_STOP.
  - If enable_req=1 and target_dir==dir before reaching 0, go to RAMP.
- WAIT_STOP:
  - Outputs: gate_enable 0, duty 0; dir keeps its last value.
  - Stop counter clears on every hall_change, otherwise increments.
  - When it reaches stop_timeout_cycles-1: dir <= DIR_NONE, go to IDLE.
  - IDLE may restart on the next cycle with the new direction.
- FAULT entry:
  - Triggered from any state by synced fault_n==0, synced overcurrent_n==0, or hall_error==1 while gate_enable==1.
  - In the next cycle: gate_enable 0, duty 0, fault_cause |= sources.
- FAULT handling:
  - Sources asserting while already in FAULT are OR'd into fault_cause.
  - dir is held.
- FAULT exit:
  - On fault_clear=1 with all sources inactive in the same cycle: fault_cause <= 0, stop counter cleared, go to WAIT_STOP.
  - fault_clear while any source is still active is ignored.
- Priority: FAULT entry beats fault_clear and every other transition.
- A target_duty change during RAMP takes effect on the next tick.

Test Plan:
- Ramp up:
  - Stimulus: ramp_div=3, ramp_step=100, target_duty=350, target_dir=DIR_CW, enable_req 0->1.
  - Response: dir=DIR_CW and gate_enable=1 one cycle later. Duty goes 100, 200, 300, 350 on successive ticks 4 cycles apart. seq_state=RUN and at_target=1 after the final step.
- Clamp and zero step:
  - Stimulus: target_duty=2000, ramp_step=0, ramp_div=0.
  - Response: duty increments by 1 per cycle and stops at exactly 1002.
- Reversal:
  - Stimulus: in RUN at duty 350 with DIR_CW, set target_dir=DIR_CCW; hall_values toggles for 20 cycles, then holds; stop_timeout_cycles=64 for the bench.
  - Response: duty ramps to 0, then gate_enable=0. IDLE is entered 64 cycles after the last hall change. dir then goes DIR_NONE->DIR_CCW and the ramp restarts.
- Overcurrent mid-ramp:
  - Stimulus: overcurrent_n low for 1 cycle during RAMP.
  - Response: gate_enable=0 and duty=0 within 4 cycles, fault_cause=3'b010, seq_state=FAULT. fault_clear pulse leads to WAIT_STOP then IDLE. fault_clear while fault_n is still low is ignored.
- Abort of ramp-down:
  - Stimulus: enable_req 1->0 at duty 500, then back to 1 after 2 ticks with the same dir.
  - Response: duty goes 400, 300, then RAMP back up to 500. gate_enable never drops.
- Reset mid-operation:
  - Stimulus: assert reset in RUN at duty 700.
  - Response: next edge gives gate_enable=0, duty=0, dir=DIR_NONE, seq_state=0, fault_cause=0.
